// File: rtl/lut_sweep_checker.sv
// Sweeps a 4-bit LUT input through codes 0..15 and counts disagreements
// against a three-code expected-high truth table.
module lut_sweep_checker #(
  parameter int unsigned SETTLE = 4,
  parameter logic [3:0]  ONE_A  = 4'd5,
  parameter logic [3:0]  ONE_B  = 4'd9,
  parameter logic [3:0]  ONE_C  = 4'd6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] x,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_one_cnt,
  output logic [4:0] err_zero_cnt,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [4:0] CNT_MAX     = 5'd16;

  state_t     state, state_n;
  logic [3:0] x_n;
  logic [7:0] settle_cnt, settle_cnt_n;
  logic [4:0] one_n, zero_n;
  logic       expected;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      x            <= 4'd0;
      settle_cnt   <= 8'd0;
      err_one_cnt  <= 5'd0;
      err_zero_cnt <= 5'd0;
    end else begin
      state        <= state_n;
      x            <= x_n;
      settle_cnt   <= settle_cnt_n;
      err_one_cnt  <= one_n;
      err_zero_cnt <= zero_n;
    end
  end

  always_comb begin
    state_n      = state;
    x_n          = x;
    settle_cnt_n = settle_cnt;
    one_n        = err_one_cnt;
    zero_n       = err_zero_cnt;
    expected     = (x == ONE_A) || (x == ONE_B) || (x == ONE_C);
    case (state)
      ST_IDLE, ST_DONE: begin
        // A start while done restarts the sweep exactly as from idle.
        if (start) begin
          state_n      = ST_SETTLE;
          x_n          = 4'd0;
          settle_cnt_n = 8'd0;
          one_n        = 5'd0;
          zero_n       = 5'd0;
        end
      end
      ST_SETTLE: begin
        settle_cnt_n = settle_cnt + 8'd1;
        if (settle_cnt == SETTLE_LAST) state_n = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (expected && !y && (err_one_cnt != CNT_MAX)) one_n = err_one_cnt + 5'd1;
        if (!expected && y && (err_zero_cnt != CNT_MAX)) zero_n = err_zero_cnt + 5'd1;
        if (x != 4'd15) begin
          x_n          = x + 4'd1;
          settle_cnt_n = 8'd0;
          state_n      = ST_SETTLE;
        end else begin
          state_n = ST_DONE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign busy      = (state == ST_SETTLE) || (state == ST_SAMPLE);
  assign done      = (state == ST_DONE);
  assign pass      = done && (err_one_cnt == 5'd0) && (err_zero_cnt == 5'd0);
  assign state_dbg = state;

endmodule
